fp_alu_scheduler: RTL
=====================

# fp_alu_scheduler

Sequencing and arbitration controller that shares one floating-point ALU datapath (combinational add/sub unit plus multi-cycle start/done multiplier) between two requesters. Each requester issues an operation through a valid/ready handshake. The scheduler grants round-robin, drives the operand and control inputs of the selected unit, waits for the result (with a multiplier watchdog), and returns it tagged with the requester ID through a single valid/ready response port.

## Interface
- W, 32, operand/result width
- TIMEOUT, 64, max cycles in MUL_WAIT before error; ≥2

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  2  00 add, 01 sub, 10 mul, 11 reserved
- req0_a, req0_b / req1_a, req1_b  in  W  operands
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index
- rsp_result  out  W  result
- rsp_overflow  out  1  unit overflow flag
- rsp_error  out  1  reserved op or multiplier timeout
- alu_a, alu_b  out  W  latched operands, shared by both units
- add_sub  out  1  0 add, 1 subtract
- add_result  in  W;  add_overflow  in  1
- mul_start  out  1  one-cycle multiplier start pulse
- mul_result  in  W;  mul_overflow  in  1;  mul_done  in  1

## Operation
- States: IDLE, ADD, MUL_START, MUL_WAIT, RESP.
- IDLE: grant = sole valid requester. If both are valid, grant goes to the one not in last_grant. reqN_ready = (state==IDLE) && grant==N && reqN_valid, combinational. On handshake, latch op, a, b and id.
  - add/sub → ADD
  - mul → MUL_START
  - reserved → RESP with rsp_error=1, result 0, overflow 0
- ADD: alu_a/alu_b/add_sub driven from latches. Capture add_result/add_overflow at end of cycle → RESP.
- MUL_START: mul_start=1 for exactly this cycle. Clear watchdog → MUL_WAIT.
- MUL_WAIT: watchdog increments each cycle.
  - mul_done=1 → capture mul_result/mul_overflow → RESP
  - watchdog reaches TIMEOUT−1 without done → RESP with rsp_error=1, result 0
  - done and timeout in the same cycle: done wins, error=0
- RESP: rsp_valid=1, fields stable. rsp_valid && rsp_ready → IDLE, last_grant ← rsp_id.
- mul_done outside MUL_WAIT is ignored.
- Only one operation is in flight; both ready lines are 0 outside IDLE.
- Operands never pass through combinationally from request ports; only latched values drive the ALU.

## Timing
- Reset (rst=0, async): state IDLE, last_grant=1 (req0 wins first tie), all outputs 0 (rsp_*, alu_a/alu_b, add_sub, mul_start, req*_ready).
- Reset mid-operation discards the in-flight op, with no response. mul_start drops immediately.
- Add/sub: handshake in cycle 0, ADD in cycle 1, rsp_valid from cycle 2. Minimum 3 cycles per op including the RESP accept.
- Mul: handshake in cycle 0, mul_start in cycle 1, MUL_WAIT from cycle 2. mul_done seen in cycle k gives rsp_valid in cycle k+1.
- Reserved op: rsp_valid in cycle 1.
- Back-pressure: with rsp_ready=0, RESP holds indefinitely with stable outputs. The next handshake happens no earlier than the cycle after the RESP accept.
- Requests wait with no timeout. Under continuous contention, grants alternate strictly.
- Watchdog width: clog2(TIMEOUT). It saturates; it does not wrap.

## Test plan
- Reset then single add: req0 op=00, a=0x3F800000, b=0x40000000, stub add_result=0x40400000 → req0_ready in cycle 0, rsp_valid in cycle 2, rsp_id=0, result 0x40400000, error 0.
- Contention: both valid from reset with op=00 and rsp_ready=1 → grant order 0,1,0,1. No requester gets two consecutive grants.
- Multiply with stub done after 5 cycles in MUL_WAIT → mul_start high exactly 1 cycle. rsp_valid on the cycle after done with mul_result and overflow propagated. Spurious mul_done in IDLE has no effect.
- Timeout: TIMEOUT=8, mul_done never asserted → rsp_valid after 8 MUL_WAIT cycles, rsp_error=1, result 0. Done coincident with the last cycle → error=0.
- Back-pressure and reserved op: req1 op=11 with rsp_ready=0 for 10 cycles → rsp_valid held, error=1, id=1, req0_ready stays 0. Accept, then IDLE.
- Async reset asserted in MUL_WAIT → all outputs 0 immediately. After release, the next request completes normally and no stale response appears.

Source files
------------

// File: rtl/fp_alu_scheduler.sv
// Round-robin sequencer sharing one add/sub unit and one start/done multiplier between two requesters.
// One op in flight; result is returned tagged with the requester id and held until accepted.
module fp_alu_scheduler #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [1:0]   req0_op_i,
  input  logic [W-1:0] req0_a_i,
  input  logic [W-1:0] req0_b_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [1:0]   req1_op_i,
  input  logic [W-1:0] req1_a_i,
  input  logic [W-1:0] req1_b_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_id_o,
  output logic [W-1:0] rsp_result_o,
  output logic         rsp_overflow_o,
  output logic         rsp_error_o,
  output logic [W-1:0] alu_a_o,
  output logic [W-1:0] alu_b_o,
  output logic         add_sub_o,
  input  logic [W-1:0] add_result_i,
  input  logic         add_overflow_i,
  output logic         mul_start_o,
  input  logic [W-1:0] mul_result_i,
  input  logic         mul_overflow_i,
  input  logic         mul_done_i
);

  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_MUL_START,
    S_MUL_WAIT,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           id_q, id_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic           grant1;
  logic           req_hs;
  logic [1:0]     req_op;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;

  // On a tie the requester that did not win last time is served.
  assign grant1 = req1_valid_i && (!req0_valid_i || !last_grant_q);

  // Ready is gated by reset so nothing can appear accepted while reset is held.
  assign req0_ready_o = rst_n_i && (state_q == S_IDLE) && req0_valid_i && !grant1;
  assign req1_ready_o = rst_n_i && (state_q == S_IDLE) && req1_valid_i && grant1;
  assign req_hs       = req0_ready_o || req1_ready_o;

  assign req_op = grant1 ? req1_op_i : req0_op_i;
  assign req_a  = grant1 ? req1_a_i  : req0_a_i;
  assign req_b  = grant1 ? req1_b_i  : req0_b_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    wd_d         = wd_q;

    case (state_q)
      S_IDLE: begin
        if (req_hs) begin
          id_d  = grant1;
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          res_d = '0;
          ovf_d = 1'b0;
          err_d = 1'b0;
          case (req_op)
            OP_ADD, OP_SUB: state_d = S_ADD;
            OP_MUL:         state_d = S_MUL_START;
            default: begin
              err_d   = 1'b1;
              state_d = S_RESP;
            end
          endcase
        end
      end

      S_ADD: begin
        res_d   = add_result_i;
        ovf_d   = add_overflow_i;
        err_d   = 1'b0;
        state_d = S_RESP;
      end

      S_MUL_START: begin
        wd_d    = '0;
        state_d = S_MUL_WAIT;
      end

      S_MUL_WAIT: begin
        // A done arriving on the last allowed cycle still counts as success.
        if (mul_done_i) begin
          res_d   = mul_result_i;
          ovf_d   = mul_overflow_i;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == WD_LAST) begin
          res_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          last_grant_d = id_q;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
    end
  end

  assign alu_a_o        = a_q;
  assign alu_b_o        = b_q;
  assign add_sub_o      = (op_q == OP_SUB);
  assign mul_start_o    = (state_q == S_MUL_START);
  assign rsp_valid_o    = (state_q == S_RESP);
  assign rsp_id_o       = id_q;
  assign rsp_result_o   = res_q;
  assign rsp_overflow_o = ovf_q;
  assign rsp_error_o    = err_q;

endmodule
